// File: rtl/serial_to_parallel_5bit_rx_if.sv
// Interface bundling the serial link inputs and the word-side outputs of
// serial_to_parallel_5bit_rx. Optional macro S2P_PARITY_CHECK_EN adds parity_err.
interface serial_to_parallel_5bit_rx_if #(
    parameter int unsigned WIDTH = 5
) ();
    logic             serial_in;
    logic             bit_en;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             frame_abort;
`ifdef S2P_PARITY_CHECK_EN
    logic             parity_err;
`endif

    // Link driver / word consumer side
    modport master (
        output serial_in,
        output bit_en,
        output frame_start,
        input  data_out,
        input  data_valid,
        input  busy,
        input  frame_abort
`ifdef S2P_PARITY_CHECK_EN
        , input parity_err
`endif
    );

    // Receiver side
    modport slave (
        input  serial_in,
        input  bit_en,
        input  frame_start,
        output data_out,
        output data_valid,
        output busy,
        output frame_abort
`ifdef S2P_PARITY_CHECK_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/serial_to_parallel_5bit_rx.sv
// Receive end of the LSB-first serial link: assembles WIDTH qualified bits into
// a word, presents it with a one-cycle data_valid pulse, and flags frames that
// are restarted by frame_start with a one-cycle frame_abort pulse.
// Optional macro S2P_PARITY_CHECK_EN: an even-parity bit follows the data bits
// (PAR state) and parity_err reports the mismatch alongside data_valid.
module serial_to_parallel_5bit_rx #(
    parameter int unsigned WIDTH = 5
) (
    input logic                           clk,
    input logic                           rst_n,
    serial_to_parallel_5bit_rx_if.slave   link
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
`ifdef S2P_PARITY_CHECK_EN
    localparam logic [1:0] ST_PAR  = 2'd2;
`endif

    logic [1:0]       state,        state_nxt;
    logic [WIDTH-1:0] sr,           sr_nxt;
    logic [CNT_W-1:0] cnt,          cnt_nxt;
    logic [WIDTH-1:0] data_out_q,   data_out_nxt;
    logic             data_valid_q, data_valid_nxt;
    logic             busy_q,       busy_nxt;
    logic             frame_abort_q, frame_abort_nxt;
`ifdef S2P_PARITY_CHECK_EN
    logic             parity_err_q, parity_err_nxt;
`endif

    logic [WIDTH-1:0] sr_shift;

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at sr[0]
    assign sr_shift = {link.serial_in, sr[WIDTH-1:1]};

    // Next-state and next-output decode
    always_comb begin
        state_nxt       = state;
        sr_nxt          = sr;
        cnt_nxt         = cnt;
        data_out_nxt    = data_out_q;
        data_valid_nxt  = 1'b0;
        frame_abort_nxt = 1'b0;
`ifdef S2P_PARITY_CHECK_EN
        parity_err_nxt  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (link.bit_en && link.frame_start) begin
                    sr_nxt    = sr_shift;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (link.bit_en) begin
                    sr_nxt = sr_shift;
                    if (link.frame_start) begin
                        // Restart: current bit is bit 0 of the new frame
                        cnt_nxt         = CNT_W'(1);
                        frame_abort_nxt = 1'b1;
                    end else if (cnt == CNT_LAST) begin
`ifdef S2P_PARITY_CHECK_EN
                        cnt_nxt   = cnt + CNT_W'(1);
                        state_nxt = ST_PAR;
`else
                        data_out_nxt   = sr_shift;
                        data_valid_nxt = 1'b1;
                        cnt_nxt        = '0;
                        state_nxt      = ST_IDLE;
`endif
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef S2P_PARITY_CHECK_EN
            ST_PAR: begin
                if (link.bit_en) begin
                    if (link.frame_start) begin
                        sr_nxt          = sr_shift;
                        cnt_nxt         = CNT_W'(1);
                        frame_abort_nxt = 1'b1;
                        state_nxt       = ST_RECV;
                    end else begin
                        // sr already holds the full word; this bit is parity only
                        data_out_nxt   = sr;
                        data_valid_nxt = 1'b1;
                        parity_err_nxt = ^{sr, link.serial_in};
                        cnt_nxt        = '0;
                        state_nxt      = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sr            <= '0;
            cnt           <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_abort_q <= 1'b0;
`ifdef S2P_PARITY_CHECK_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            sr            <= sr_nxt;
            cnt           <= cnt_nxt;
            data_out_q    <= data_out_nxt;
            data_valid_q  <= data_valid_nxt;
            busy_q        <= busy_nxt;
            frame_abort_q <= frame_abort_nxt;
`ifdef S2P_PARITY_CHECK_EN
            parity_err_q  <= parity_err_nxt;
`endif
        end
    end

    assign link.data_out    = data_out_q;
    assign link.data_valid  = data_valid_q;
    assign link.busy        = busy_q;
    assign link.frame_abort = frame_abort_q;
`ifdef S2P_PARITY_CHECK_EN
    assign link.parity_err  = parity_err_q;
`endif

endmodule
